// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, loads IF/ID,
// applies branch/jr/jump redirects and parks one fetched word while ID is stalled.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
    typedef enum logic [1:0] {IFID_KEEP, IFID_BUBBLE, IFID_MEM, IFID_BUF} ifid_sel_t;

    state_t      state, state_nx;
    ifid_sel_t   ifid_sel;
    logic [31:0] pc, pc_nx, pc_plus4;
    logic [31:0] buf_instr, buf_pc4, stale_addr;
    logic        buf_load, stale_load;
    logic        redirect;
    logic [31:0] target_raw, target;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = branch_taken | jr | jump;

    // Oldest instruction wins: the branch sits deepest in the pipe, then JR, then J.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        target_raw = '0;
        if (branch_taken)
            target_raw = branch_target;
        else if (jr)
            target_raw = jr_target;
        else if (jump)
            target_raw = {if_id_pc4[31:28], jump_index, 2'b00};
        target = target_raw & ~32'h3;
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        buf_load   = 1'b0;
        stale_load = 1'b0;
        ifid_sel   = IFID_KEEP;
        imem_req   = 1'b0;
        imem_addr  = pc;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                if (redirect) begin
                    pc_nx    = target;
                    ifid_sel = IFID_BUBBLE;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_nx    = target;
                    ifid_sel = IFID_BUBBLE;
                    // An unacked request must still run to completion at its original address.
                    if (!imem_ack) begin
                        stale_load = 1'b1;
                        state_nx   = DISCARD;
                    end
                end else if (imem_ack) begin
                    pc_nx = pc_plus4;
                    if (stall) begin
                        buf_load = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        ifid_sel = IFID_MEM;
                    end
                end else if (!stall) begin
                    ifid_sel = IFID_BUBBLE;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nx    = target;
                    ifid_sel = IFID_BUBBLE;
                    state_nx = FETCH;
                end else if (!stall) begin
                    ifid_sel = IFID_BUF;
                    state_nx = FETCH;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = stale_addr;
                ifid_sel  = IFID_BUBBLE;
                if (redirect)
                    pc_nx = target;
                if (imem_ack)
                    state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            buf_instr  <= '0;
            buf_pc4    <= '0;
            stale_addr <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (buf_load) begin
                buf_instr <= imem_rdata;
                buf_pc4   <= pc_plus4;
            end
            if (stale_load)
                stale_addr <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            case (ifid_sel)
                IFID_BUBBLE: if_id_valid <= 1'b0;
                IFID_MEM: begin
                    if_id_instr <= imem_rdata;
                    if_id_pc4   <= pc_plus4;
                    if_id_valid <= 1'b1;
                end
                IFID_BUF: begin
                    if_id_instr <= buf_instr;
                    if_id_pc4   <= buf_pc4;
                    if_id_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
